llc_mem_responder: RTL
======================

Name: llc_mem_responder

Overview:
- Memory-side responder for the LLC memory channel.
- Accepts llc_mem_req transactions from llc_core, services reads and writes against an internal line-wide backing store, and returns read data on llc_mem_rsp.
- Used as the DRAM stand-in for LLC unit benches and FPGA bring-up.
- Single outstanding read; writes are posted and produce no response.

Parameters:
LINE_BITS, 128, width of one cache line (matches line_t).
ADDR_BITS, 28, width of line address (matches line_addr_t).
MEM_LINES, 256, number of lines in the backing store; power of two, at least 2.
RD_LATENCY, 4, cycles from read acceptance to llc_mem_rsp_valid; range 1..15.

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
llc_mem_req_valid  in  1  request valid
llc_mem_req_ready  out  1  request ready
llc_mem_req_hwrite  in  1  1 = write, 0 = read
llc_mem_req_addr  in  ADDR_BITS  line address
llc_mem_req_line  in  LINE_BITS  write data
llc_mem_rsp_valid  out  1  read response valid
llc_mem_rsp_ready  in  1  read response ready
llc_mem_rsp_line  out  LINE_BITS  read data
init_done  out  1  backing store initialised
rd_count  out  16  accepted reads, wraps modulo 2^16
wr_count  out  16  accepted writes, wraps modulo 2^16

Behaviour:
- Index = llc_mem_req_addr[log2(MEM_LINES)-1:0]. Upper address bits are ignored, so addresses alias.
- Reset values: llc_mem_req_ready=0, llc_mem_rsp_valid=0, llc_mem_rsp_line=0, init_done=0, rd_count=0, wr_count=0, FSM=INIT, init pointer=0.
- FSM states: INIT, IDLE, WAIT, RSP.
- INIT:
  - Writes 0 to entry[ptr] each cycle; ptr increments.
  - After MEM_LINES cycles (ptr wraps to 0), moves to IDLE and sets init_done=1, registered.
  - init_done stays 1 until the next reset.
  - llc_mem_req_ready=0 throughout INIT.
- llc_mem_req_ready = (state==IDLE), combinational from the state register. No combinational path from any input to ready.
- IDLE, accept edge (valid & ready):
  - Write: entry[index] <= line at that edge. wr_count++. Stays IDLE, so back-to-back writes are accepted one per cycle.
  - Read: entry[index] is captured into a response register at that edge. rd_count++.
    - RD_LATENCY==1: go to RSP.
    - Otherwise: go to WAIT with counter = RD_LATENCY-1.
- WAIT: counter decrements each cycle; on counter==1 go to RSP. llc_mem_rsp_valid rises exactly RD_LATENCY cycles after the accept edge.
- RSP:
  - llc_mem_rsp_valid=1 and llc_mem_rsp_line=captured data.
  - Both are held stable while !llc_mem_rsp_ready.
  - On valid & ready: valid deasserts next cycle, go to IDLE. A new request can be accepted the cycle after the response handshake.
  - llc_mem_rsp_line keeps its last value after the handshake; it is don't-care when valid=0.
- Read-after-write ordering: a read accepted the cycle after a write to the same index returns the new data (write-first storage).
- Read data is snapshotted at acceptance, so it is unaffected by later writes. Later writes cannot overlap a pending read, since ready is 0 outside IDLE.
- llc_mem_req_valid may be asserted during INIT, WAIT or RSP. It is simply not accepted; the request stays pending under standard valid/ready rules.
- Counters wrap 0xFFFF -> 0x0000 with no flag.
- Reset asserted mid-operation:
  - Any pending read and response are dropped immediately (async).
  - Counters clear and the store re-initialises to 0 through INIT.
- Storage: a synchronous single-port array of MEM_LINES x LINE_BITS. The INIT sweep and request writes share the write port, which is legal because they are mutually exclusive by state.

Test Plan:
- Reset release, MEM_LINES=256 -> ready=0 for 256 cycles; init_done=1 and ready=1 on cycle 257; read of addr 0x05 returns 0.
- Write addr 0x10 line 0xDEADBEEF..., then read 0x10 the next cycle, RD_LATENCY=4 -> rsp_valid rises exactly 4 cycles after read accept, line=0xDEADBEEF...; wr_count=1, rd_count=1.
- Hold rsp_ready=0 for 10 cycles during RSP while the requester holds a new valid read -> rsp_valid and line stable, req_ready=0 throughout; after rsp_ready=1 the handshake completes and the new read is accepted the following cycle.
- Aliasing: write addr 0x100 data A, read addr 0x000 -> returns A (MEM_LINES=256).
- 65537 back-to-back writes -> wr_count=0x0001, one accept per cycle, no responses generated.
- Assert rst during WAIT of a pending read -> rsp_valid never rises; after re-init, ready returns, counters=0, and the previously written location reads 0.

Source files
------------

// File: rtl/llc_mem_responder.sv
// llc_mem_responder: memory-side responder for the LLC memory channel.
// It zero-fills a line-wide backing store after reset, then serves llc_mem_req:
// writes are posted, and each read returns one llc_mem_rsp. Only one read is outstanding.
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   llc_mem_req_valid/ready       request handshake (ready is a function of state only)
//   llc_mem_req_hwrite/addr/line  1=write/0=read, line address, write data
//   llc_mem_rsp_valid/ready/line  read response handshake and data
//   init_done                     backing store zero-fill complete (sticky until reset)
//   rd_count, wr_count            accepted reads / writes, wrapping modulo 2^16
module llc_mem_responder #(
  parameter int LINE_BITS  = 128,
  parameter int ADDR_BITS  = 28,
  parameter int MEM_LINES  = 256,
  parameter int RD_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 llc_mem_req_valid,
  output logic                 llc_mem_req_ready,
  input  logic                 llc_mem_req_hwrite,
  input  logic [ADDR_BITS-1:0] llc_mem_req_addr,
  input  logic [LINE_BITS-1:0] llc_mem_req_line,
  output logic                 llc_mem_rsp_valid,
  input  logic                 llc_mem_rsp_ready,
  output logic [LINE_BITS-1:0] llc_mem_rsp_line,
  output logic                 init_done,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  localparam int IDX_BITS = $clog2(MEM_LINES);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_BITS-1:0]  init_ptr_q, init_ptr_d;
  logic [3:0]           wait_cnt_q, wait_cnt_d;
  logic [LINE_BITS-1:0] rsp_line_q, rsp_line_d;
  logic                 init_done_q, init_done_d;
  logic [15:0]          rd_count_q, rd_count_d;
  logic [15:0]          wr_count_q, wr_count_d;

  // Single write port, shared by the zero-fill sweep and request writes.
  // The two never coincide because the sweep runs only in INIT.
  logic [LINE_BITS-1:0] mem [MEM_LINES];
  logic                 mem_we;
  logic [IDX_BITS-1:0]  mem_waddr;
  logic [LINE_BITS-1:0] mem_wdata;

  logic [IDX_BITS-1:0]  req_idx;
  logic                 unused_addr_hi;

  // Upper address bits are deliberately ignored, so addresses alias modulo MEM_LINES.
  assign req_idx        = llc_mem_req_addr[IDX_BITS-1:0];
  assign unused_addr_hi = ^llc_mem_req_addr[ADDR_BITS-1:IDX_BITS];

  // Both handshake outputs decode the state register alone,
  // so there is no combinational path from any input.
  assign llc_mem_req_ready = (state_q == ST_IDLE);
  assign llc_mem_rsp_valid = (state_q == ST_RSP);
  assign llc_mem_rsp_line  = rsp_line_q;
  assign init_done         = init_done_q;
  assign rd_count          = rd_count_q;
  assign wr_count          = wr_count_q;

  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_line_d  = rsp_line_q;
    init_done_d = init_done_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    mem_we      = 1'b0;
    mem_waddr   = req_idx;
    mem_wdata   = llc_mem_req_line;

    case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_ptr_q;
        mem_wdata  = '0;
        init_ptr_d = init_ptr_q + 1'b1;
        // The last entry is being cleared; the pointer wraps back to 0 on this edge.
        if (init_ptr_q == IDX_BITS'(MEM_LINES - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end

      ST_IDLE: begin
        if (llc_mem_req_valid) begin
          if (llc_mem_req_hwrite) begin
            mem_we     = 1'b1;
            wr_count_d = wr_count_q + 16'd1;
          end else begin
            // Snapshot the line at acceptance. A write accepted on the previous
            // edge is already in the array, which gives write-first ordering.
            rsp_line_d = mem[req_idx];
            rd_count_d = rd_count_q + 16'd1;
            if (RD_LATENCY == 1) begin
              state_d = ST_RSP;
            end else begin
              state_d    = ST_WAIT;
              wait_cnt_d = 4'(RD_LATENCY - 1);
            end
          end
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == 4'd1) begin
          state_d = ST_RSP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      ST_RSP: begin
        if (llc_mem_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_ptr_q  <= '0;
      wait_cnt_q  <= '0;
      rsp_line_q  <= '0;
      init_done_q <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_line_q  <= rsp_line_d;
      init_done_q <= init_done_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // The array has no reset; its contents are cleared by the INIT sweep instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule
